// File: rtl/pic24_icsp_target.sv
// PIC24 ICSP target: synchronizes MCLRn/PGC/PGD, checks the entry key, then decodes SIX/REGOUT transfers.
// Optional ICSP_ENH_KEY_EN macro adds the enhanced entry key and the enh_mode output.
module pic24_icsp_target #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] ENTER_KEY   = 32'h4D434851
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        MCLRn,
   input  logic        PGCx,
   input  logic        PGDx_in,
   output logic        PGDx_out,
   output logic        PGDx_oe,
   output logic [23:0] instr,
   output logic        instr_valid,
   input  logic [15:0] visi,
   output logic        visi_ack,
   output logic        icsp_active
`ifdef ICSP_ENH_KEY_EN
   ,
   output logic        enh_mode
`endif
);

   typedef enum logic [2:0] {
      S_OFF, S_KEY, S_FIRST, S_CMD, S_SIX, S_RIDLE, S_RDATA
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] mclr_sync_q, pgc_sync_q, pgd_sync_q;
   logic                   mclr_prev_q, pgc_prev_q;
   logic [31:0]            sh_q;
   logic [4:0]             cnt_q;
   logic [23:0]            instr_q;
   logic                   instr_valid_q, visi_ack_q, active_q;
   logic                   pgd_out_q, pgd_oe_q;
   logic                   mclr_s, pgc_s, pgd_s;
   logic                   mclr_rise, pgc_rise, pgc_fall;
   logic                   enh_match;

   assign mclr_s    = mclr_sync_q[SYNC_STAGES-1];
   assign pgc_s     = pgc_sync_q[SYNC_STAGES-1];
   assign pgd_s     = pgd_sync_q[SYNC_STAGES-1];
   assign mclr_rise = mclr_s & ~mclr_prev_q;
   assign pgc_rise  = pgc_s & ~pgc_prev_q;
   assign pgc_fall  = ~pgc_s & pgc_prev_q;

`ifdef ICSP_ENH_KEY_EN
   localparam logic [31:0] ENH_KEY = 32'h4D434850;
   logic enh_q;
   assign enh_match = (sh_q == ENH_KEY);
   assign enh_mode  = enh_q;
`else
   assign enh_match = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         mclr_sync_q <= '0;
         pgc_sync_q  <= '0;
         pgd_sync_q  <= '0;
         mclr_prev_q <= 1'b0;
         pgc_prev_q  <= 1'b0;
      end else begin
         mclr_sync_q <= {mclr_sync_q[SYNC_STAGES-2:0], MCLRn};
         pgc_sync_q  <= {pgc_sync_q[SYNC_STAGES-2:0], PGCx};
         pgd_sync_q  <= {pgd_sync_q[SYNC_STAGES-2:0], PGDx_in};
         mclr_prev_q <= mclr_s;
         pgc_prev_q  <= pgc_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= S_OFF;
         sh_q          <= '0;
         cnt_q         <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         visi_ack_q    <= 1'b0;
         active_q      <= 1'b0;
         pgd_out_q     <= 1'b0;
         pgd_oe_q      <= 1'b0;
`ifdef ICSP_ENH_KEY_EN
         enh_q         <= 1'b0;
`endif
      end else begin
         instr_valid_q <= 1'b0;
         visi_ack_q    <= 1'b0;
         // MCLRn low while active drops everything and waits for a fresh key
         if (state_q != S_OFF && state_q != S_KEY && !mclr_s) begin
            state_q   <= S_KEY;
            sh_q      <= '0;
            cnt_q     <= '0;
            active_q  <= 1'b0;
            pgd_out_q <= 1'b0;
            pgd_oe_q  <= 1'b0;
`ifdef ICSP_ENH_KEY_EN
            enh_q     <= 1'b0;
`endif
         end else begin
            case (state_q)
               S_OFF: begin
                  if (!mclr_s) begin
                     state_q <= S_KEY;
                     sh_q    <= '0;
                  end
               end
               S_KEY: begin
                  if (mclr_rise) begin
                     cnt_q <= '0;
                     if (sh_q == ENTER_KEY || enh_match) begin
                        state_q  <= S_FIRST;
                        active_q <= 1'b1;
`ifdef ICSP_ENH_KEY_EN
                        enh_q    <= enh_match;
`endif
                     end else begin
                        state_q <= S_OFF;
                     end
                  end else if (pgc_rise) begin
                     sh_q <= {sh_q[30:0], pgd_s};
                  end
               end
               S_FIRST: begin
                  if (pgc_rise) begin
                     if (cnt_q == 5'd8) begin
                        state_q <= S_SIX;
                        cnt_q   <= '0;
                     end else begin
                        cnt_q <= cnt_q + 5'd1;
                     end
                  end
               end
               S_CMD: begin
                  if (pgc_rise) begin
                     sh_q <= {sh_q[30:0], pgd_s};
                     if (cnt_q == 5'd3) begin
                        cnt_q <= '0;
                        if ({sh_q[2:0], pgd_s} == 4'b0000)      state_q <= S_SIX;
                        else if ({sh_q[2:0], pgd_s} == 4'b0001) state_q <= S_RIDLE;
                     end else begin
                        cnt_q <= cnt_q + 5'd1;
                     end
                  end
               end
               S_SIX: begin
                  if (pgc_rise) begin
                     sh_q <= {sh_q[30:0], pgd_s};
                     if (cnt_q == 5'd23) begin
                        instr_q       <= {sh_q[22:0], pgd_s};
                        instr_valid_q <= 1'b1;
                        state_q       <= S_CMD;
                        cnt_q         <= '0;
                     end else begin
                        cnt_q <= cnt_q + 5'd1;
                     end
                  end
               end
               S_RIDLE: begin
                  if (pgc_rise && cnt_q != 5'd8) begin
                     cnt_q <= cnt_q + 5'd1;
                  end else if (pgc_fall && cnt_q == 5'd8) begin
                     sh_q       <= {16'h0000, visi};
                     visi_ack_q <= 1'b1;
                     pgd_oe_q   <= 1'b1;
                     pgd_out_q  <= visi[15];
                     cnt_q      <= '0;
                     state_q    <= S_RDATA;
                  end
               end
               S_RDATA: begin
                  if (pgc_rise && cnt_q != 5'd16) begin
                     cnt_q <= cnt_q + 5'd1;
                  end else if (pgc_fall) begin
                     if (cnt_q == 5'd16) begin
                        pgd_oe_q  <= 1'b0;
                        pgd_out_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_CMD;
                     end else begin
                        sh_q      <= {sh_q[30:0], 1'b0};
                        pgd_out_q <= sh_q[14];
                     end
                  end
               end
               default: state_q <= S_OFF;
            endcase
         end
      end
   end

   assign PGDx_out    = pgd_out_q & pgd_oe_q;
   assign PGDx_oe     = pgd_oe_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign visi_ack    = visi_ack_q;
   assign icsp_active = active_q;

endmodule

// File: tb/tb_pic24_icsp_target.sv
// Directed bench for pic24_icsp_target: key entry, SIX, REGOUT readback, abort, bad key, reset mid-read.
module tb_pic24_icsp_target;

   logic        clk = 1'b0;
   logic        rstn, MCLRn, PGCx, PGDx_in;
   logic        PGDx_out, PGDx_oe;
   logic [23:0] instr;
   logic        instr_valid;
   logic [15:0] visi;
   logic        visi_ack, icsp_active;
`ifdef ICSP_ENH_KEY_EN
   logic        enh_mode;
`endif

   int checks = 0;
   int errors = 0;
   int iv_cnt = 0;
   int ack_cnt = 0;
   int oe_cycles = 0;
   int bad_out = 0;
   logic [15:0] rd;

   pic24_icsp_target #(.SYNC_STAGES(2), .ENTER_KEY(32'h4D434851)) dut (
      .clk(clk), .rstn(rstn), .MCLRn(MCLRn), .PGCx(PGCx), .PGDx_in(PGDx_in),
      .PGDx_out(PGDx_out), .PGDx_oe(PGDx_oe), .instr(instr), .instr_valid(instr_valid),
      .visi(visi), .visi_ack(visi_ack), .icsp_active(icsp_active)
`ifdef ICSP_ENH_KEY_EN
      , .enh_mode(enh_mode)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (instr_valid) iv_cnt++;
      if (visi_ack) ack_cnt++;
      if (PGDx_oe) oe_cycles++;
      if (!PGDx_oe && PGDx_out) bad_out++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // low phase with data set up, then high phase: 5 clk each
   task automatic pgc_bit(input logic b);
      PGDx_in = b;
      #50 PGCx = 1'b1;
      #50 PGCx = 1'b0;
   endtask

   task automatic send(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) pgc_bit(v[i]);
   endtask

   task automatic read_bit(output logic b, output logic oe);
      PGDx_in = 1'b0;
      #50 PGCx = 1'b1;
      #30 b = PGDx_out;
      oe = PGDx_oe;
      #20 PGCx = 1'b0;
   endtask

   task automatic enter(input logic [31:0] key);
      MCLRn = 1'b0;
      #50;
      send(key, 32);
      MCLRn = 1'b1;
      #50;
   endtask

   initial begin
      logic b, oe;
      int iv0;
      rstn = 1'b0; MCLRn = 1'b1; PGCx = 1'b0; PGDx_in = 1'b0; visi = 16'h0000;
      #50;
      check("rst_oe", 32'(PGDx_oe), 0);
      check("rst_out", 32'(PGDx_out), 0);
      check("rst_instr", 32'(instr), 0);
      check("rst_iv", 32'(instr_valid), 0);
      check("rst_ack", 32'(visi_ack), 0);
      check("rst_active", 32'(icsp_active), 0);
      rstn = 1'b1;
      #100;
      check("idle_state_off", 32'(dut.state_q), 0);

      // entry + first SIX without a command
      iv_cnt = 0;
      enter(32'h4D434851);
      check("entry_active", 32'(icsp_active), 1);
      send(32'h0, 9);
      send(32'h040200, 24);
      #50;
      check("six1_instr", 32'(instr), 32'h040200);
      check("six1_ivcnt", 32'(iv_cnt), 1);
      check("six1_active", 32'(icsp_active), 1);

      send(32'h0, 4);
      send(32'hABCDEF, 24);
      #50;
      check("six2_instr", 32'(instr), 32'hABCDEF);
      check("six2_ivcnt", 32'(iv_cnt), 2);

      // unknown command is dropped, next SIX still decodes
      send(32'h5, 4);
      send(32'h0, 4);
      send(32'h123456, 24);
      #50;
      check("six3_instr", 32'(instr), 32'h123456);
      check("six3_ivcnt", 32'(iv_cnt), 3);

      // REGOUT
      visi = 16'hA5C3;
      ack_cnt = 0;
      send(32'h1, 4);
      send(32'h0, 4);
      check("ridle_oe", 32'(PGDx_oe), 0);
      oe_cycles = 0;
      send(32'h0, 4);
      rd = '0;
      for (int i = 0; i < 16; i++) begin
         read_bit(b, oe);
         rd = {rd[14:0], b};
         check("rdata_oe", 32'(oe), 1);
      end
      #50;
      check("regout_data", 32'(rd), 32'hA5C3);
      check("regout_ack", 32'(ack_cnt), 1);
      check("regout_oe_end", 32'(PGDx_oe), 0);
      check("regout_oe_cycles", 32'(oe_cycles), 160);
      check("regout_instr_kept", 32'(instr), 32'h123456);

      // abort mid-SIX, then re-enter
      send(32'h0, 4);
      send(32'hFFF, 12);
      MCLRn = 1'b0;
      #50;
      check("abort_ivcnt", 32'(iv_cnt), 3);
      check("abort_oe", 32'(PGDx_oe), 0);
      check("abort_active", 32'(icsp_active), 0);
      check("abort_state_key", 32'(dut.state_q), 1);
      enter(32'h4D434851);
      check("reentry_active", 32'(icsp_active), 1);
      send(32'h0, 9);
      send(32'h0A0B0C, 24);
      #50;
      check("reentry_instr", 32'(instr), 32'h0A0B0C);
      check("reentry_ivcnt", 32'(iv_cnt), 4);

      // wrong key
      enter(32'h4D434852);
      check("badkey_state_off", 32'(dut.state_q), 0);
      check("badkey_active", 32'(icsp_active), 0);
      send(32'h0, 9);
      send(32'h777777, 24);
      #50;
      check("badkey_ivcnt", 32'(iv_cnt), 4);

      // enhanced key
      enter(32'h4D434850);
`ifdef ICSP_ENH_KEY_EN
      check("enh_active", 32'(icsp_active), 1);
      check("enh_mode", 32'(enh_mode), 1);
`else
      check("enh_active", 32'(icsp_active), 0);
      check("enh_state_off", 32'(dut.state_q), 0);
`endif

      // reset during RDATA bit 5
      enter(32'h4D434851);
      check("rst_pre_active", 32'(icsp_active), 1);
`ifdef ICSP_ENH_KEY_EN
      check("enh_mode_std", 32'(enh_mode), 0);
`endif
      send(32'h0, 9);
      send(32'h5A5A5A, 24);
      #50;
      check("rst_pre_instr", 32'(instr), 32'h5A5A5A);
      send(32'h1, 4);
      send(32'h0, 8);
      for (int i = 0; i < 5; i++) read_bit(b, oe);
      check("rst_pre_oe", 32'(PGDx_oe), 1);
      rstn = 1'b0;
      #10;
      check("rst_mid_oe", 32'(PGDx_oe), 0);
      check("rst_mid_out", 32'(PGDx_out), 0);
      check("rst_mid_instr", 32'(instr), 0);
      check("rst_mid_active", 32'(icsp_active), 0);
      check("rst_mid_ack", 32'(visi_ack), 0);
      check("rst_mid_state", 32'(dut.state_q), 0);
      #40;
      rstn = 1'b1;
      #100;
      iv0 = iv_cnt;
      send(32'h0, 9);
      send(32'h123456, 24);
      #50;
      check("post_rst_active", 32'(icsp_active), 0);
      check("post_rst_ivcnt", 32'(iv_cnt), 32'(iv0));
      check("post_rst_instr", 32'(instr), 0);
      check("out_zero_when_oe0", 32'(bad_out), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pic24_icsp_target.md
PIC24_ICSP_TARGET -- requirements
Module: pic24_icsp_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, 2, number of synchronizer flops on MCLRn, PGCx and PGDx_in (minimum 2).
REQ-002 SHALL have parameter ENTER_KEY, 32'h4D434851, ICSP entry key.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port MCLRn  input  1  master clear from the programmer, asynchronous to clk.
REQ-006 SHALL have port PGCx  input  1  programming clock from the programmer, asynchronous to clk.
REQ-007 SHALL have port PGDx_in  input  1  programming data from the programmer.
REQ-008 SHALL have port PGDx_out  output  1  programming data driven to the programmer; 0 whenever PGDx_oe=0.
REQ-009 SHALL have port PGDx_oe  output  1  1 = target drives PGDx.
REQ-010 SHALL have port instr  output  24  last received SIX instruction.
REQ-011 SHALL have port instr_valid  output  1  one-clk pulse when instr updates.
REQ-012 SHALL have port visi  input  16  data returned by REGOUT; sampled once per REGOUT.
REQ-013 SHALL have port visi_ack  output  1  one-clk pulse in the cycle visi is captured.
REQ-014 SHALL have port icsp_active  output  1  1 while in ICSP mode.

Function
REQ-015 SHALL detect a PGC rising edge when synchronized PGCx goes 0->1 and sample synchronized PGDx_in in that cycle; PGC falling edge detection mirrors this; PGC high and low phases are each at least 3 clk.
REQ-016 SHALL implement states OFF, KEY, FIRST, CMD, SIX, RIDLE, RDATA.
REQ-017 OFF: synchronized MCLRn=0 -> KEY with the key shift register cleared.
REQ-018 KEY: each PGC rise shifts PGD into a 32-bit register MSB-first (sliding window); on MCLRn rise, window==ENTER_KEY -> FIRST with icsp_active=1, otherwise -> OFF.
REQ-019 FIRST: 9 PGC rises are ignored (command padding) -> SIX; the first transfer after entry is always SIX.
REQ-020 CMD: 4 bits MSB-first; 4'b0000 -> SIX, 4'b0001 -> RIDLE, any other code is discarded -> CMD.
REQ-021 SIX: 24 bits MSB-first; in the cycle after the 24th rise, instr is loaded and instr_valid pulses -> CMD.
REQ-022 RIDLE: 8 PGC rises ignored; on the 8th fall, visi is captured, visi_ack pulses, PGDx_oe=1 and PGDx_out=visi[15] -> RDATA.
REQ-023 RDATA: 16 bits MSB-first; PGDx_out shifts to the next bit on each PGC fall; PGDx_oe drops on the fall after the 16th rise -> CMD.
REQ-024 SHALL, when MCLRn=0 in any state other than OFF/KEY, abort the transfer without instr_valid, set PGDx_oe=0 and icsp_active=0, and go to KEY (re-entry).
REQ-025 SHALL keep bit counters saturating-free: each counter is reset on state entry and never wraps within a state.

Reset
REQ-026 rstn=0 at a clk rise SHALL force OFF with PGDx_out=0, PGDx_oe=0, instr=0, instr_valid=0, visi_ack=0, icsp_active=0, and all shift registers, counters and synchronizers cleared; this applies mid-transfer too.
REQ-027 After rstn=1 a target SHALL require a fresh MCLRn low + key to become active.

Configuration
REQ-028 With macro ICSP_ENH_KEY_EN defined, KEY SHALL also accept 32'h4D434850 (enhanced entry) and add output enh_mode (1 bit, reset 0, set when the enhanced key matched, cleared on exit); without it, that key -> OFF and the port is absent.

Verification
REQ-029 MCLRn pulse, key 4D434851, MCLRn high, 9 clocks + 24'h040200 -> instr=040200, one instr_valid, icsp_active=1.
REQ-030 Key 4D434852 then MCLRn high -> state OFF, icsp_active=0, no instr_valid for following clocks.
REQ-031 Active, cmd 0001, 8 idle clocks, visi=16'hA5C3 -> one visi_ack, programmer samples A5C3 MSB-first, PGDx_oe 1 only during the 16 data clocks.
REQ-032 Active, cmd 0000 then 12 of 24 bits, MCLRn low -> no instr_valid, PGDx_oe=0, icsp_active=0, state KEY; correct key re-enters.
REQ-033 rstn low during RDATA bit 5 -> PGDx_oe=0 next clk and all outputs at reset values.
REQ-034 With ICSP_ENH_KEY_EN, key 4D434850 -> icsp_active=1, enh_mode=1; without it -> OFF.
